// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS core constants: phases, opcodes, widths
package mips_pkg;

    localparam int XLEN  = 32;
    localparam int OPC_W = 6;

    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;

    localparam logic [OPC_W-1:0] ADD  = 6'h00;
    localparam logic [OPC_W-1:0] ADDI = 6'h08;
    localparam logic [OPC_W-1:0] SW   = 6'h2B;
    localparam logic [OPC_W-1:0] LW   = 6'h23;
    localparam logic [OPC_W-1:0] BGTZ = 6'h07;
    localparam logic [OPC_W-1:0] J    = 6'h02;

endpackage

// File: rtl/ifetch_pc_if.sv
// rtl/ifetch_pc_if.sv - instruction memory bus between fetch stage and imem
interface ifetch_pc_if;
    import mips_pkg::*;

    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;

    modport master (output imem_addr, input imem_rdata);
    modport slave  (input imem_addr, output imem_rdata);

endinterface

// File: rtl/ifetch_pc_target.sv
// rtl/ifetch_pc_target.sv - J/BGTZ target and taken resolution (combinational)
module ifetch_target
    import mips_pkg::*;
(
    input  logic [25:0]     ir_idx,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] rs_data,
    input  logic            j_en,
    input  logic            bgtz_en,
    output logic [XLEN-1:0] target,
    output logic            taken
);

    logic [XLEN-1:0] j_tgt;
    logic [XLEN-1:0] b_off;
    logic [XLEN-1:0] b_tgt;

    assign j_tgt = {pc_plus4[31:28], ir_idx, 2'b00};
    assign b_off = {{14{ir_idx[15]}}, ir_idx[15:0], 2'b00};
    // modulo 2^32: backward branches below zero wrap
    assign b_tgt = pc_plus4 + b_off;

    assign taken  = j_en | (bgtz_en & ($signed(rs_data) > 32'sd0));
    assign target = j_en ? j_tgt : b_tgt;

endmodule

// File: rtl/ifetch_pc.sv
// rtl/ifetch_pc.sv - fetch/PC stage; IFETCH_PERF_EN adds retired/taken counters
module ifetch_pc
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         curr_state,
    input  logic               Branch,
    input  logic               j_en,
    input  logic               bgtz_en,
    input  logic [XLEN-1:0]    rs_data,
    ifetch_pc_if.master        imem,
    output logic [XLEN-1:0]    ir,
    output logic [OPC_W-1:0]   instr,
    output logic [XLEN-1:0]    pc,
    output logic [XLEN-1:0]    pc_plus4
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]        retired_cnt,
    output logic [31:0]        taken_cnt
`endif
);

    logic            redir_q;
    logic [XLEN-1:0] tgt_q;
    logic [XLEN-1:0] target;
    logic            taken;

    assign pc_plus4       = pc + 32'd4;
    assign imem.imem_addr = pc;
    assign instr          = ir[31:26];

    ifetch_target u_target (
        .ir_idx   (ir[25:0]),
        .pc_plus4 (pc_plus4),
        .rs_data  (rs_data),
        .j_en     (j_en),
        .bgtz_en  (bgtz_en),
        .target   (target),
        .taken    (taken)
    );

    // Illegal phases (4-7) fall through the default arm and hold everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_PC;
            ir      <= '0;
            redir_q <= 1'b0;
            tgt_q   <= '0;
        end else begin
            case (curr_state)
                S0: begin
                    ir      <= imem.imem_rdata;
                    redir_q <= 1'b0;
                end
                S2: begin
                    if (Branch) begin
                        redir_q <= taken;
                        tgt_q   <= target;
                    end
                end
                S3: pc <= redir_q ? tgt_q : pc_plus4;
                default: ;
            endcase
        end
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_cnt <= '0;
            taken_cnt   <= '0;
        end else if (curr_state == S3) begin
            retired_cnt <= retired_cnt + 32'd1;
            if (redir_q) begin
                taken_cnt <= taken_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
